// File: rtl/board_move_sequencer_pkg.sv
// Shared definitions for the checkers move sequencer: square codes, FSM
// state encodings, packed command layout and the legality check.
package board_move_sequencer_pkg;

    // Square state codes as stored in the board state RAM
    localparam logic [7:0] SQ_EMPTY   = 8'h00;
    localparam logic [7:0] SQ_P1      = 8'h01;
    localparam logic [7:0] SQ_P2      = 8'h02;
    localparam logic [7:0] SQ_P1_KING = 8'h03;
    localparam logic [7:0] SQ_P2_KING = 8'h04;

    localparam int BOARD_N_DEF = 8;

    // FSM state encodings
    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_CHECK   = 4'd1;
    localparam logic [3:0] ST_SRC_SET = 4'd2;
    localparam logic [3:0] ST_SRC_STB = 4'd3;
    localparam logic [3:0] ST_CAP_SET = 4'd4;
    localparam logic [3:0] ST_CAP_STB = 4'd5;
    localparam logic [3:0] ST_DST_SET = 4'd6;
    localparam logic [3:0] ST_DST_STB = 4'd7;
    localparam logic [3:0] ST_DONE    = 4'd8;

    // Packed 57-bit queue entry; field offsets match the struct below
    localparam int CMD_W           = 57;
    localparam int CMD_SRC_X_LSB   = 0;
    localparam int CMD_SRC_Y_LSB   = 8;
    localparam int CMD_DST_X_LSB   = 16;
    localparam int CMD_DST_Y_LSB   = 24;
    localparam int CMD_PIECE_LSB   = 32;
    localparam int CMD_CAP_X_LSB   = 40;
    localparam int CMD_CAP_Y_LSB   = 48;
    localparam int CMD_CAPTURE_BIT = 56;

    typedef struct packed {
        logic       capture;
        logic [7:0] cap_y;
        logic [7:0] cap_x;
        logic [7:0] piece;
        logic [7:0] dst_y;
        logic [7:0] dst_x;
        logic [7:0] src_y;
        logic [7:0] src_x;
    } move_cmd_t;

    // A move is legal when every used coordinate is on the board and the
    // piece actually moves; the captured square only counts when used.
    function automatic logic cmd_is_legal(input move_cmd_t c, input int board_n);
        logic ok;
        ok = (int'(c.src_x) < board_n) && (int'(c.src_y) < board_n) &&
             (int'(c.dst_x) < board_n) && (int'(c.dst_y) < board_n);
        if (c.capture) begin
            ok = ok && (int'(c.cap_x) < board_n) && (int'(c.cap_y) < board_n);
        end
        if ((c.src_x == c.dst_x) && (c.src_y == c.dst_y)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/board_move_sequencer_move_cmd_fifo.sv
// Synchronous command FIFO. No bypass: an entry pushed at an edge is visible
// at the head only after that edge. A push into a full FIFO is dropped even if
// a pop happens in the same cycle.
module move_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 57
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointer and occupancy update; pointers wrap naturally at DEPTH (power of 2)
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (reset && push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/board_move_sequencer.sv
// Turns one queued checkers move into an ordered train of single-square RAM
// writes: clear source, clear captured square (optional), write destination.
// Each write is a SET cycle (address/data settle, wea=0) followed by a STB
// cycle (same address/data, wea=1). All RAM-side outputs are registered and
// are computed from the next state so they line up with the state's cycle.
// Handshake: a command is taken at a clock edge where cmd_valid && cmd_ready;
// cmd_ready is simply "queue not full" and does not depend on cmd_valid.
module board_move_sequencer
    import board_move_sequencer_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter int         BOARD_N    = BOARD_N_DEF,
    parameter logic [7:0] CLEAR_CODE = 8'h00
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [7:0]                    cmd_src_x,
    input  logic [7:0]                    cmd_src_y,
    input  logic [7:0]                    cmd_dst_x,
    input  logic [7:0]                    cmd_dst_y,
    input  logic [7:0]                    cmd_piece,
    input  logic                          cmd_capture,
    input  logic [7:0]                    cmd_cap_x,
    input  logic [7:0]                    cmd_cap_y,
    output logic [7:0]                    locX_state,
    output logic [7:0]                    locY_state,
    output logic [7:0]                    update_state,
    output logic                          wea_state_ram,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [3:0]                    dbg_state
);

    move_cmd_t  push_cmd;
    logic [CMD_W-1:0] fifo_rdata;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_push;
    logic       fifo_pop;

    logic [3:0] state_q, state_d;
    move_cmd_t  cmd_q, cmd_d;
    logic [7:0] loc_x_q, loc_x_d;
    logic [7:0] loc_y_q, loc_y_d;
    logic [7:0] upd_q, upd_d;
    logic       wea_q, wea_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    assign push_cmd = '{capture: cmd_capture, cap_y: cmd_cap_y, cap_x: cmd_cap_x,
                        piece: cmd_piece, dst_y: cmd_dst_y, dst_x: cmd_dst_x,
                        src_y: cmd_src_y, src_x: cmd_src_x};

    assign fifo_push = cmd_valid && reset;
    assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;

    move_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (push_cmd),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Next state, working command and registered RAM-side outputs
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        loc_x_d = loc_x_q;
        loc_y_d = loc_y_q;
        upd_d   = upd_q;
        wea_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    cmd_d   = move_cmd_t'(fifo_rdata);
                    state_d = ST_CHECK;
                    // Flag is raised while in CHECK so err lines up with that cycle
                    err_d   = !cmd_is_legal(move_cmd_t'(fifo_rdata), BOARD_N);
                end
            end
            ST_CHECK:   state_d = cmd_is_legal(cmd_q, BOARD_N) ? ST_SRC_SET : ST_IDLE;
            ST_SRC_SET: state_d = ST_SRC_STB;
            ST_SRC_STB: state_d = cmd_q.capture ? ST_CAP_SET : ST_DST_SET;
            ST_CAP_SET: state_d = ST_CAP_STB;
            ST_CAP_STB: state_d = ST_DST_SET;
            ST_DST_SET: state_d = ST_DST_STB;
            ST_DST_STB: state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        // Outputs follow the state being entered; outside writes they hold
        case (state_d)
            ST_SRC_SET, ST_SRC_STB: begin
                loc_x_d = cmd_d.src_x;
                loc_y_d = cmd_d.src_y;
                upd_d   = CLEAR_CODE;
            end
            ST_CAP_SET, ST_CAP_STB: begin
                loc_x_d = cmd_d.cap_x;
                loc_y_d = cmd_d.cap_y;
                upd_d   = CLEAR_CODE;
            end
            ST_DST_SET, ST_DST_STB: begin
                loc_x_d = cmd_d.dst_x;
                loc_y_d = cmd_d.dst_y;
                upd_d   = cmd_d.piece;
            end
            default: ;
        endcase

        wea_d  = (state_d == ST_SRC_STB) || (state_d == ST_CAP_STB) ||
                 (state_d == ST_DST_STB);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers; reset abandons any move in the same edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            loc_x_q <= '0;
            loc_y_q <= '0;
            upd_q   <= '0;
            wea_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            loc_x_q <= loc_x_d;
            loc_y_q <= loc_y_d;
            upd_q   <= upd_d;
            wea_q   <= wea_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready     = !fifo_full;
    assign busy          = (state_q != ST_IDLE) || !fifo_empty;
    assign locX_state    = loc_x_q;
    assign locY_state    = loc_y_q;
    assign update_state  = upd_q;
    assign wea_state_ram = wea_q;
    assign done          = done_q;
    assign err           = err_q;
    assign dbg_state     = state_q;

endmodule
